fb_pixel_writer: RTL and testbench

- Sink end of the rasterizer address stream.
- Accepts 19-bit frame-buffer pixel addresses (y*640+x) from the circle/line rasterizers and queues them in a small FIFO.
- Writes each pixel to frame-buffer SRAM through a req/ack port, using the primitive colour.
- Drives `stop` back to the rasterizer as backpressure.
- Pulses `write_done` once every pixel of a primitive has been committed to memory.

---
 rtl/fb_pixel_writer_if.sv | 13 +
 rtl/fb_pixel_writer.sv | 153 +++++++++++++++
 tb/tb_fb_pixel_writer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pixel_writer_if.sv
// Frame-buffer SRAM write port: address/data/request driven by the writer, ack returned by memory.
interface fb_pixel_writer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wen;
  logic              mem_ack;

  modport master (output mem_addr, output mem_wdata, output mem_wen, input mem_ack);
  modport slave  (input mem_addr, input mem_wdata, input mem_wen, output mem_ack);
endinterface

// File: rtl/fb_pixel_writer.sv
// Rasterizer pixel sink: FIFO of {colour, address} drained to frame-buffer SRAM via req/ack.
// Optional duplicate-address suppression when FB_PIXEL_WRITER_DEDUP_EN is defined.
module fb_pixel_writer #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int STOP_SLACK = 2,
  parameter int FB_SIZE    = 307200
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              prim_start,
  input  logic [DATA_W-1:0] color,
  input  logic [ADDR_W-1:0] pix_addr,
  input  logic              pix_valid,
  input  logic              prim_done,
  output logic              stop,
  output logic              write_done,
  output logic              busy,
  output logic              err,
  fb_pixel_writer_if.master mem
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + ADDR_W;

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ENT_W-1:0]  fifo_mem [DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] color_q;
  logic              err_q, err_d;
  logic              armed_q, armed_d;
  logic              done_q;
  logic              pdone_q;

  logic fifo_empty, fifo_full, in_range, dup, room;
  logic push, pop, err_set, done_fire;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign in_range   = (pix_addr < ADDR_W'(FB_SIZE));

  // A pop in WAIT_ACK only happens on the ack edge, which keeps writes at one per cycle.
  assign pop  = !fifo_empty && ((state_q == IDLE) || mem.mem_ack);
  // A full FIFO still accepts a pixel when the head leaves on the same edge.
  assign room = !fifo_full || pop;

`ifdef FB_PIXEL_WRITER_DEDUP_EN
  logic [ADDR_W-1:0] last_q;
  logic              last_v_q;

  assign dup = last_v_q && (pix_addr == last_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_q   <= '0;
      last_v_q <= 1'b0;
    end else if (prim_start) begin
      last_v_q <= 1'b0;
    end else if (push) begin
      last_q   <= pix_addr;
      last_v_q <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign push      = pix_valid && in_range && !dup && room;
  assign err_set   = pix_valid && (!in_range || (!dup && !room));
  assign done_fire = armed_q && fifo_empty && !push && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pop) state_d = WAIT_ACK;
      WAIT_ACK: if (mem.mem_ack && !pop) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (prim_start) err_d = 1'b0;
    if (err_set)    err_d = 1'b1;
  end

  // A rising prim_done arms; a new primitive or a delivered pulse disarms.
  always_comb begin
    armed_d = armed_q;
    if (done_fire)             armed_d = 1'b0;
    if (prim_start)            armed_d = 1'b0;
    if (prim_done && !pdone_q) armed_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {color_q, pix_addr};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      color_q  <= '0;
      err_q    <= 1'b0;
      armed_q  <= 1'b0;
      done_q   <= 1'b0;
      pdone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      armed_q <= armed_d;
      done_q  <= done_fire;
      pdone_q <= prim_done;
      if (prim_start) color_q <= color;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q          <= rd_ptr_q + 1'b1;
        {wdata_q, addr_q} <= fifo_mem[rd_ptr_q];
      end
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wen   = (state_q == WAIT_ACK);

  assign stop       = (count_q >= CNT_W'(DEPTH - STOP_SLACK));
  assign busy       = !fifo_empty || (state_q == WAIT_ACK);
  assign err        = err_q;
  assign write_done = done_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: vector table, directed corner sequences and random traffic vs. a queue model.
module tb_fb_pixel_writer;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 8;
  localparam int STOP_SLACK = 2;
  localparam int FB_SIZE    = 307200;
`ifdef FB_PIXEL_WRITER_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              prim_start = 1'b0;
  logic [DATA_W-1:0] color = '0;
  logic [ADDR_W-1:0] pix_addr = '0;
  logic              pix_valid = 1'b0;
  logic              prim_done = 1'b0;
  logic              stop, write_done, busy, err;

  fb_pixel_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  fb_pixel_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .STOP_SLACK(STOP_SLACK), .FB_SIZE(FB_SIZE)
  ) dut (
    .clk(clk), .n_rst(n_rst), .prim_start(prim_start), .color(color),
    .pix_addr(pix_addr), .pix_valid(pix_valid), .prim_done(prim_done),
    .stop(stop), .write_done(write_done), .busy(busy), .err(err),
    .mem(mem_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: pixel queue plus a single outstanding-write slot.
  logic [DATA_W+ADDR_W-1:0] mq[$];
  logic              m_wen, m_err, m_armed, m_done, m_pdone, m_last_v;
  logic [ADDR_W-1:0] m_addr, m_last;
  logic [DATA_W-1:0] m_data, m_color;
  logic [ADDR_W-1:0] act_wr[$];
  logic [ADDR_W-1:0] exp_wr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wen = 0; m_err = 0; m_armed = 0; m_done = 0; m_pdone = 0; m_last_v = 0;
    m_addr = '0; m_last = '0; m_data = '0; m_color = '0;
  endtask

  task automatic model_step();
    bit do_pop, in_rng, is_dup, has_room, do_push, fire;
    do_pop   = (mq.size() != 0) && (!m_wen || mem_bus.mem_ack);
    in_rng   = pix_addr < FB_SIZE;
    is_dup   = DEDUP && m_last_v && (pix_addr == m_last);
    has_room = (mq.size() < DEPTH) || do_pop;
    do_push  = pix_valid && in_rng && !is_dup && has_room;
    fire     = m_armed && (mq.size() == 0) && !do_push && !m_wen;
    if (m_wen && mem_bus.mem_ack) exp_wr.push_back(m_addr);
    if (do_pop) begin
      {m_data, m_addr} = mq.pop_front();
      m_wen = 1;
    end else if (m_wen && mem_bus.mem_ack) begin
      m_wen = 0;
    end
    if (do_push) mq.push_back({m_color, pix_addr});
    if (pix_valid && (!in_rng || (!is_dup && !has_room))) m_err = 1;
    else if (prim_start) m_err = 0;
    if (fire) m_armed = 0;
    if (prim_start) m_armed = 0;
    if (prim_done && !m_pdone) m_armed = 1;
    m_pdone = prim_done;
    m_done  = fire;
    if (prim_start) m_last_v = 0;
    else if (do_push) begin m_last = pix_addr; m_last_v = 1; end
    if (prim_start) m_color = color;
  endtask

  task automatic compare_all();
    chk("wen", mem_bus.mem_wen, m_wen);
    if (m_wen) begin
      chk("addr", mem_bus.mem_addr, m_addr);
      chk("wdata", mem_bus.mem_wdata, m_data);
    end
    chk("stop", stop, mq.size() >= DEPTH - STOP_SLACK);
    chk("busy", busy, (mq.size() != 0) || m_wen);
    chk("err", err, m_err);
    chk("write_done", write_done, m_done);
  endtask

  task automatic cycle();
    if (mem_bus.mem_wen && mem_bus.mem_ack) act_wr.push_back(mem_bus.mem_addr);
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic quiet();
    prim_start = 0; pix_valid = 0;
  endtask

  task automatic clear_logs();
    act_wr.delete(); exp_wr.delete();
  endtask

  typedef struct {
    logic ps; logic [DATA_W-1:0] col; logic pv; logic [ADDR_W-1:0] pa; logic pd; logic ack;
    logic e_wen; logic [ADDR_W-1:0] e_addr; logic [DATA_W-1:0] e_data;
    logic e_busy; logic e_err; logic e_done;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1, 8'hA5, 0, 0,      0, 1, 0, 0,      8'h00, 0, 0, 0};
    tbl[1]  = '{0, 8'h00, 1, 77120,  0, 1, 0, 0,      8'h00, 1, 0, 0};
    tbl[2]  = '{0, 8'h00, 0, 0,      0, 1, 1, 77120,  8'hA5, 1, 0, 0};
    tbl[3]  = '{0, 8'h00, 0, 0,      1, 1, 0, 0,      8'h00, 0, 0, 0};
    tbl[4]  = '{0, 8'h00, 0, 0,      1, 1, 0, 0,      8'h00, 0, 0, 1};
    tbl[5]  = '{0, 8'h00, 0, 0,      0, 1, 0, 0,      8'h00, 0, 0, 0};
    tbl[6]  = '{0, 8'h00, 0, 0,      0, 1, 0, 0,      8'h00, 0, 0, 0};
    tbl[7]  = '{0, 8'h00, 1, 307200, 0, 1, 0, 0,      8'h00, 0, 1, 0};
    tbl[8]  = '{0, 8'h00, 0, 0,      0, 1, 0, 0,      8'h00, 0, 1, 0};
    tbl[9]  = '{1, 8'h3C, 0, 0,      0, 1, 0, 0,      8'h00, 0, 0, 0};
    tbl[10] = '{0, 8'h00, 1, 307199, 0, 1, 0, 0,      8'h00, 1, 0, 0};
    tbl[11] = '{0, 8'h00, 0, 0,      0, 1, 1, 307199, 8'h3C, 1, 0, 0};
    tbl[12] = '{0, 8'h00, 0, 0,      0, 1, 0, 0,      8'h00, 0, 0, 0};

    mem_bus.mem_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #3 n_rst = 1'b1;
    #1;
    chk("reset_wen", mem_bus.mem_wen, 0);
    chk("reset_busy", busy, 0);
    chk("reset_stop", stop, 0);
    chk("reset_err", err, 0);
    chk("reset_done", write_done, 0);
    compare_all();

    // Single pixel, clip and err clearing from the vector table.
    for (int i = 0; i < 13; i++) begin
      prim_start = tbl[i].ps; color = tbl[i].col; pix_valid = tbl[i].pv;
      pix_addr = tbl[i].pa; prim_done = tbl[i].pd; mem_bus.mem_ack = tbl[i].ack;
      cycle();
      chk($sformatf("tbl%0d_wen", i), mem_bus.mem_wen, tbl[i].e_wen);
      if (tbl[i].e_wen) begin
        chk($sformatf("tbl%0d_addr", i), mem_bus.mem_addr, tbl[i].e_addr);
        chk($sformatf("tbl%0d_data", i), mem_bus.mem_wdata, tbl[i].e_data);
      end
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
      chk($sformatf("tbl%0d_done", i), write_done, tbl[i].e_done);
    end
    quiet(); prim_done = 0;

    // Backpressure: ack low, stream pixels 0..9.
    clear_logs();
    mem_bus.mem_ack = 0;
    prim_start = 1; color = 8'h11; cycle(); quiet();
    for (int k = 0; k < 10; k++) begin
      pix_valid = 1; pix_addr = ADDR_W'(k);
      cycle();
      chk($sformatf("bp_stop%0d", k), stop, k >= 6);
      chk($sformatf("bp_err%0d", k), err, k == 9);
    end
    quiet();
    mem_bus.mem_ack = 1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk($sformatf("bp_b2b_wen%0d", i), mem_bus.mem_wen, i < 8);
      if (i < 8) chk($sformatf("bp_b2b_addr%0d", i), mem_bus.mem_addr, i + 1);
    end
    chk("bp_nwrites", act_wr.size(), 9);
    for (int i = 0; i < act_wr.size() && i < 9; i++)
      chk($sformatf("bp_order%0d", i), act_wr[i], i);

    // Ack stall for 5 cycles.
    mem_bus.mem_ack = 0;
    prim_start = 1; color = 8'h77; cycle(); quiet();
    pix_valid = 1; pix_addr = 500; cycle();
    pix_addr = 501; cycle();
    quiet();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_wen", mem_bus.mem_wen, 1);
      chk("stall_addr", mem_bus.mem_addr, 500);
      chk("stall_data", mem_bus.mem_wdata, 8'h77);
    end
    mem_bus.mem_ack = 1;
    cycle();
    chk("stall_next_addr", mem_bus.mem_addr, 501);
    chk("stall_next_wen", mem_bus.mem_wen, 1);
    cycle();
    chk("stall_drained", mem_bus.mem_wen, 0);

    // Asynchronous reset with three pixels queued and a write outstanding.
    mem_bus.mem_ack = 0;
    for (int k = 0; k < 4; k++) begin
      pix_valid = 1; pix_addr = ADDR_W'(600 + k); cycle();
    end
    quiet();
    chk("pre_rst_wen", mem_bus.mem_wen, 1);
    chk("pre_rst_busy", busy, 1);
    #2 n_rst = 0;
    #1;
    chk("rst_async_wen", mem_bus.mem_wen, 0);
    chk("rst_async_stop", stop, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_done", write_done, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 n_rst = 1;
    clear_logs();
    mem_bus.mem_ack = 1;
    for (int i = 0; i < 10; i++) cycle();
    chk("rst_no_writes", act_wr.size(), 0);

    // Duplicate suppression sequence.
    clear_logs();
    prim_start = 1; color = 8'h42; cycle(); quiet();
    for (int k = 0; k < 4; k++) begin
      pix_valid = 1;
      pix_addr = (k == 2) ? ADDR_W'(101) : ADDR_W'(100);
      cycle();
    end
    quiet();
    for (int i = 0; i < 6; i++) cycle();
    chk("dedup_nwrites", act_wr.size(), DEDUP ? 3 : 4);
    if (act_wr.size() >= 3) begin
      chk("dedup_w0", act_wr[0], 100);
      chk("dedup_w1", act_wr[1], DEDUP ? 101 : 100);
      chk("dedup_w2", act_wr[2], DEDUP ? 100 : 101);
    end
    chk("dedup_err", err, 0);

    // Random traffic against the model.
    clear_logs();
    for (int n = 0; n < 1500; n++) begin
      int r;
      prim_start = ($urandom_range(0, 63) == 0);
      color = DATA_W'($urandom);
      pix_valid = !prim_start && ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      if (r == 0) pix_addr = ADDR_W'(FB_SIZE + $urandom_range(0, 3));
      else if (r < 4) pix_addr = pix_addr;
      else if (r == 4) pix_addr = ADDR_W'(FB_SIZE - 1);
      else pix_addr = ADDR_W'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) prim_done = ~prim_done;
      mem_bus.mem_ack = ($urandom_range(0, 3) != 0);
      cycle();
    end
    quiet();
    mem_bus.mem_ack = 1;
    for (int i = 0; i < 12; i++) cycle();
    chk("rand_nwrites", act_wr.size(), exp_wr.size());
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++)
      if (act_wr[i] !== exp_wr[i]) chk($sformatf("rand_wr%0d", i), act_wr[i], exp_wr[i]);
    chk("rand_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
